// File: rtl/csr_access_ctrl.sv
// CSR access controller: shadowed register bank behind a 3-state access FSM
// (read/write/set/clear), one access per three cycles, sticky integrity alert.
module csr_access_ctrl #(
  parameter int unsigned      Width      = 32,
  parameter int unsigned      NumRegs    = 4,
  parameter bit               ShadowCopy = 1'b1,
  parameter logic [Width-1:0] ResetValue = '0
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             req_i,
  output logic             gnt_o,
  input  logic [1:0]       addr_i,
  input  logic [1:0]       op_i,
  input  logic [Width-1:0] wdata_i,
  output logic             rvalid_o,
  output logic [Width-1:0] rdata_o,
  output logic             err_o,
  output logic             alert_o,
  input  logic             alert_clr_i
);

  typedef enum logic [1:0] {
    StIdle,
    StExec,
    StResp
  } state_e;

  typedef enum logic [1:0] {
    OpRead  = 2'b00,
    OpWrite = 2'b01,
    OpSet   = 2'b10,
    OpClear = 2'b11
  } op_e;

  state_e           state_q, state_d;
  op_e              op_q, op_d;
  logic [1:0]       addr_q, addr_d;
  logic [Width-1:0] wdata_q, wdata_d;
  logic [Width-1:0] old_q, old_d;
  logic             err_q, err_d;
  logic             alert_q, alert_d;

  logic [3:0]       wr_en;
  logic [3:0]       rd_err;
  logic [Width-1:0] wr_data;
  logic [Width-1:0] rd_data [4];
  logic [Width-1:0] cur_val;
  logic             cur_err;
  logic             oor;
  logic             do_wr;

  // Shadow holds the inverted value; any disagreement is an integrity error.
  for (genvar r = 0; r < 4; r++) begin : gen_reg
    if (r < NumRegs) begin : gen_on
      logic [Width-1:0] main_q;
      logic [Width-1:0] shadow_q;

      always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
          main_q   <= ResetValue;
          shadow_q <= ~ResetValue;
        end else if (wr_en[r]) begin
          main_q   <= wr_data;
          shadow_q <= ~wr_data;
        end
      end

      assign rd_data[r] = main_q;
      assign rd_err[r]  = ShadowCopy && (main_q != ~shadow_q);
    end else begin : gen_off
      assign rd_data[r] = '0;
      assign rd_err[r]  = 1'b0;
    end
  end

  assign oor     = 32'(addr_q) >= NumRegs;
  assign cur_val = oor ? '0 : rd_data[addr_q];
  assign cur_err = oor | rd_err[addr_q];

  always_comb begin
    unique case (op_q)
      OpWrite: wr_data = wdata_q;
      OpSet:   wr_data = cur_val | wdata_q;
      OpClear: wr_data = cur_val & ~wdata_q;
      default: wr_data = cur_val;
    endcase
  end

  assign do_wr = (state_q == StExec) && !oor &&
                 ((op_q == OpWrite) ||
                  ((op_q != OpRead) && (wdata_q != '0)));

  always_comb begin
    wr_en = '0;
    if (do_wr) wr_en[addr_q] = 1'b1;
  end

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    op_d    = op_q;
    wdata_d = wdata_q;
    old_d   = old_q;
    err_d   = err_q;
    gnt_o   = 1'b0;
    unique case (state_q)
      StIdle: begin
        gnt_o = req_i;
        if (req_i) begin
          state_d = StExec;
          addr_d  = addr_i;
          op_d    = op_e'(op_i);
          wdata_d = wdata_i;
        end
      end
      StExec: begin
        old_d   = cur_val;
        err_d   = cur_err;
        state_d = StResp;
      end
      StResp:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // A new error in the same cycle beats the clear.
  assign alert_d = (|rd_err) | (alert_q & ~alert_clr_i);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= StIdle;
      addr_q  <= '0;
      op_q    <= OpRead;
      wdata_q <= '0;
      old_q   <= '0;
      err_q   <= 1'b0;
      alert_q <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      op_q    <= op_d;
      wdata_q <= wdata_d;
      old_q   <= old_d;
      err_q   <= err_d;
      alert_q <= alert_d;
    end
  end

  assign rvalid_o = (state_q == StResp);
  assign rdata_o  = rvalid_o ? old_q : '0;
  assign err_o    = rvalid_o & err_q;
  assign alert_o  = alert_q;

endmodule

// File: tb/tb_csr_access_ctrl.sv
// Self-checking bench for csr_access_ctrl: directed scenarios plus
// randomized accesses against an array model of the register bank.
module tb_csr_access_ctrl;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req = 1'b0;
  logic [1:0]  addr = '0;
  logic [1:0]  op = '0;
  logic [31:0] wdata = '0;
  logic        alert_clr = 1'b0;

  logic        gnt, rvalid, err, alert;
  logic [31:0] rdata;
  logic        gnt3, rvalid3, err3, alert3;
  logic [31:0] rdata3;

  int checks = 0;
  int errors = 0;
  int wr_cnt = 0;
  logic [31:0] model [4];
  logic [31:0] model3 [4];

  localparam logic [1:0] RD = 2'b00;
  localparam logic [1:0] WR = 2'b01;
  localparam logic [1:0] ST = 2'b10;
  localparam logic [1:0] CL = 2'b11;

  always #5 clk = ~clk;

  csr_access_ctrl dut (
    .clk_i(clk), .rst_ni(rst_n), .req_i(req), .gnt_o(gnt),
    .addr_i(addr), .op_i(op), .wdata_i(wdata),
    .rvalid_o(rvalid), .rdata_o(rdata), .err_o(err),
    .alert_o(alert), .alert_clr_i(alert_clr)
  );

  csr_access_ctrl #(.NumRegs(3)) dut3 (
    .clk_i(clk), .rst_ni(rst_n), .req_i(req), .gnt_o(gnt3),
    .addr_i(addr), .op_i(op), .wdata_i(wdata),
    .rvalid_o(rvalid3), .rdata_o(rdata3), .err_o(err3),
    .alert_o(alert3), .alert_clr_i(alert_clr)
  );

  always @(posedge clk) if (|dut.wr_en) wr_cnt++;

  initial begin
    #500000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  task automatic access(input logic [1:0] a, input logic [1:0] o,
                        input logic [31:0] d, input bit sel,
                        output logic g, output logic g_ex,
                        output logic rv_ex, output logic rv,
                        output logic [31:0] rd, output logic e);
    @(negedge clk);
    req = 1'b1; addr = a; op = o; wdata = d;
    #1 g = sel ? gnt3 : gnt;
    @(negedge clk);
    req = 1'($urandom_range(0, 1));
    wdata = $urandom;
    rv_ex = sel ? rvalid3 : rvalid;
    #1 g_ex = sel ? gnt3 : gnt;
    @(negedge clk);
    req = 1'b0;
    rv = sel ? rvalid3 : rvalid;
    rd = sel ? rdata3 : rdata;
    e  = sel ? err3 : err;
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    req = 1'b1;
    #3;
    checks++;
    if (gnt !== 1'b1) begin
      errors++; $display("FAIL rst_gnt_hi got %b exp 1", gnt);
    end
    req = 1'b0;
    #1;
    checks++;
    if ({gnt, rvalid, rdata, err, alert} !== 36'h0) begin
      errors++;
      $display("FAIL rst_outs got %b %b %h %b %b exp 0",
               gnt, rvalid, rdata, err, alert);
    end
    for (int i = 0; i < 4; i++) begin
      model[i] = 32'h0; model3[i] = 32'h0;
    end
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    checks++;
    if ($isunknown({gnt, rvalid, rdata, err, alert})) begin
      errors++; $display("FAIL post_rst_x got %b exp known", rvalid);
    end
  endtask

  task automatic test_write_read;
    logic g, gx, rvx, rv, e;
    logic [31:0] rd;
    int c0;
    c0 = wr_cnt;
    access(2'd1, WR, 32'hDEADBEEF, 1'b0, g, gx, rvx, rv, rd, e);
    checks++;
    if ({g, gx, rvx, rv, e} !== 5'b10010 || rd !== 32'h0) begin
      errors++;
      $display("FAIL wr1 got g%b gx%b rx%b rv%b e%b %h exp 1 0 0 1 0 0",
               g, gx, rvx, rv, e, rd);
    end
    checks++;
    if (wr_cnt - c0 != 1) begin
      errors++; $display("FAIL wr1_pulse got %0d exp 1", wr_cnt - c0);
    end
    model[1] = 32'hDEADBEEF;
    access(2'd1, RD, 32'h0, 1'b0, g, gx, rvx, rv, rd, e);
    checks++;
    if ({g, gx, rvx, rv, e} !== 5'b10010 || rd !== 32'hDEADBEEF) begin
      errors++;
      $display("FAIL rd1 got rv%b e%b %h exp 1 0 deadbeef", rv, e, rd);
    end
  endtask

  task automatic test_set_clear;
    logic g, gx, rvx, rv, e;
    logic [31:0] rd;
    logic [1:0] ops [4];
    logic [31:0] ds [4];
    logic [31:0] exp_rd [4];
    ops = '{WR, ST, CL, RD};
    ds = '{32'hF0, 32'h0F, 32'hF0, 32'h0};
    exp_rd = '{model[2], 32'hF0, 32'hFF, 32'h0F};
    for (int i = 0; i < 4; i++) begin
      access(2'd2, ops[i], ds[i], 1'b0, g, gx, rvx, rv, rd, e);
      checks++;
      if (rv !== 1'b1 || e !== 1'b0 || rd !== exp_rd[i]) begin
        errors++;
        $display("FAIL setclr%0d got rv%b e%b %h exp 1 0 %h",
                 i, rv, e, rd, exp_rd[i]);
      end
    end
    model[2] = 32'h0F;
  endtask

  task automatic test_set_zero;
    logic g, gx, rvx, rv, e;
    logic [31:0] rd;
    int c0;
    access(2'd0, WR, 32'h1234, 1'b0, g, gx, rvx, rv, rd, e);
    model[0] = 32'h1234;
    c0 = wr_cnt;
    access(2'd0, ST, 32'h0, 1'b0, g, gx, rvx, rv, rd, e);
    checks++;
    if (wr_cnt != c0 || rd !== 32'h1234 || e !== 1'b0) begin
      errors++;
      $display("FAIL set0 got pulses %0d %h e%b exp 0 1234 0",
               wr_cnt - c0, rd, e);
    end
    access(2'd0, RD, 32'h0, 1'b0, g, gx, rvx, rv, rd, e);
    checks++;
    if (rd !== 32'h1234) begin
      errors++; $display("FAIL set0_rd got %h exp 1234", rd);
    end
  endtask

  task automatic test_random;
    logic g, gx, rvx, rv, e;
    logic [31:0] rd, d, old, nv;
    logic [1:0] a, o;
    int c0, exp_wr;
    for (int i = 0; i < 40; i++) begin
      a = 2'($urandom_range(0, 3));
      o = 2'($urandom_range(0, 3));
      d = ($urandom_range(0, 3) == 0) ? 32'h0 : $urandom;
      old = model[a];
      case (o)
        WR:      nv = d;
        ST:      nv = old | d;
        CL:      nv = old & ~d;
        default: nv = old;
      endcase
      exp_wr = (o == WR || (o != RD && d != 0)) ? 1 : 0;
      c0 = wr_cnt;
      access(a, o, d, 1'b0, g, gx, rvx, rv, rd, e);
      checks++;
      if ({g, gx, rvx, rv, e} !== 5'b10010 || rd !== old ||
          wr_cnt - c0 != exp_wr) begin
        errors++;
        $display("FAIL rnd%0d a%0d op%0d got g%b gx%b rx%b rv%b e%b %h w%0d exp %h w%0d",
                 i, a, o, g, gx, rvx, rv, e, rd, wr_cnt - c0, old, exp_wr);
      end
      model[a] = nv;
    end
    checks++;
    if (alert !== 1'b0) begin
      errors++; $display("FAIL rnd_alert got %b exp 0", alert);
    end
  endtask

  task automatic test_alert;
    logic g, gx, rvx, rv, e;
    logic [31:0] rd;
    @(negedge clk);
    force dut.gen_reg[1].gen_on.shadow_q = ~model[1] ^ 32'h100;
    @(negedge clk);
    checks++;
    if (alert !== 1'b1) begin
      errors++; $display("FAIL alert_set got %b exp 1", alert);
    end
    repeat (3) @(negedge clk);
    checks++;
    if (alert !== 1'b1) begin
      errors++; $display("FAIL alert_sticky got %b exp 1", alert);
    end
    access(2'd1, RD, 32'h0, 1'b0, g, gx, rvx, rv, rd, e);
    checks++;
    if (e !== 1'b1 || rd !== model[1]) begin
      errors++;
      $display("FAIL alert_rd got e%b %h exp 1 %h", e, rd, model[1]);
    end
    alert_clr = 1'b1;
    @(negedge clk);
    alert_clr = 1'b0;
    checks++;
    if (alert !== 1'b1) begin
      errors++; $display("FAIL alert_clr_persist got %b exp 1", alert);
    end
    release dut.gen_reg[1].gen_on.shadow_q;
    access(2'd1, WR, 32'hA5A5, 1'b0, g, gx, rvx, rv, rd, e);
    model[1] = 32'hA5A5;
    alert_clr = 1'b1;
    @(negedge clk);
    alert_clr = 1'b0;
    checks++;
    if (alert !== 1'b0) begin
      errors++; $display("FAIL alert_clr got %b exp 0", alert);
    end
    access(2'd1, RD, 32'h0, 1'b0, g, gx, rvx, rv, rd, e);
    checks++;
    if (e !== 1'b0 || rd !== 32'hA5A5) begin
      errors++; $display("FAIL alert_fix got e%b %h exp 0 a5a5", e, rd);
    end
  endtask

  task automatic test_reset_abort;
    logic g, gx, rvx, rv, e;
    logic [31:0] rd;
    int c0, seen;
    c0 = wr_cnt;
    seen = 0;
    @(negedge clk);
    req = 1'b1; addr = 2'd3; op = WR; wdata = 32'h55;
    @(negedge clk);
    req = 1'b0;
    rst_n = 1'b0;
    #1;
    if (rvalid) seen++;
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      model[i] = 32'h0; model3[i] = 32'h0;
    end
    req = 1'b1;
    #1;
    checks++;
    if (gnt !== 1'b1) begin
      errors++; $display("FAIL abort_gnt got %b exp 1", gnt);
    end
    req = 1'b0;
    #1;
    checks++;
    if (gnt !== 1'b0) begin
      errors++; $display("FAIL abort_gnt_lo got %b exp 0", gnt);
    end
    repeat (3) begin
      @(negedge clk);
      if (rvalid) seen++;
    end
    checks++;
    if (seen != 0 || wr_cnt != c0) begin
      errors++;
      $display("FAIL abort got rvalids %0d writes %0d exp 0 0",
               seen, wr_cnt - c0);
    end
    access(2'd3, RD, 32'h0, 1'b0, g, gx, rvx, rv, rd, e);
    checks++;
    if (rd !== 32'h0 || e !== 1'b0) begin
      errors++; $display("FAIL abort_rd got %h e%b exp 0 0", rd, e);
    end
  endtask

  task automatic test_out_of_range;
    logic g, gx, rvx, rv, e;
    logic [31:0] rd;
    access(2'd2, WR, 32'h77, 1'b1, g, gx, rvx, rv, rd, e);
    model3[2] = 32'h77;
    access(2'd3, WR, 32'h1, 1'b1, g, gx, rvx, rv, rd, e);
    checks++;
    if (rv !== 1'b1 || e !== 1'b1 || rd !== 32'h0) begin
      errors++;
      $display("FAIL oor got rv%b e%b %h exp 1 1 0", rv, e, rd);
    end
    for (int i = 0; i < 3; i++) begin
      access(2'(i), RD, 32'h0, 1'b1, g, gx, rvx, rv, rd, e);
      checks++;
      if (e !== 1'b0 || rd !== model3[i]) begin
        errors++;
        $display("FAIL oor_rd%0d got e%b %h exp 0 %h", i, e, rd, model3[i]);
      end
    end
    checks++;
    if (alert3 !== 1'b0) begin
      errors++; $display("FAIL oor_alert got %b exp 0", alert3);
    end
  endtask

  initial begin
    test_reset();
    test_write_read();
    test_set_clear();
    test_set_zero();
    test_random();
    test_alert();
    test_reset_abort();
    test_out_of_range();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
